// File: rtl/rv32i_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path:
// FSM state encoding, instruction classes, opcodes, ALU and mux select codes.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_IL,
        CLS_S,
        CLS_B,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } instr_cls_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_IL    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // ALU codes are {funct7[5], funct3}; branches reuse the low three bits
    // as the comparison selector while the branch qualifier is high.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] WSEL_ALU   = 3'd0;
    localparam logic [2:0] WSEL_LOAD  = 3'd1;
    localparam logic [2:0] WSEL_LUI   = 3'd2;
    localparam logic [2:0] WSEL_AUIPC = 3'd3;
    localparam logic [2:0] WSEL_PC4   = 3'd4;

    localparam logic [1:0] SIZE_B  = 2'b00;
    localparam logic [1:0] SIZE_H  = 2'b01;
    localparam logic [1:0] SIZE_W  = 2'b10;
    localparam logic [1:0] SIZE_BU = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic instr_cls_e classify(input logic [6:0] opcode);
        instr_cls_e cls;
        case (opcode)
            OP_R:     cls = CLS_R;
            OP_I:     cls = CLS_I;
            OP_IL:    cls = CLS_IL;
            OP_S:     cls = CLS_S;
            OP_B:     cls = CLS_B;
            OP_LUI:   cls = CLS_LUI;
            OP_AUIPC: cls = CLS_AUIPC;
            OP_JAL:   cls = CLS_JAL;
            OP_JALR:  cls = CLS_JALR;
            default:  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of the latched instruction word into its class
// and the datapath selects that stay stable for the life of the instruction.
module instr_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  cls_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_src_o,
    output logic [2:0]  wb_sel_o,
    output logic [1:0]  store_size_o,
    output logic [1:0]  load_size_o
);

    instr_cls_e cls;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_bits;

    assign funct3      = instr_i[14:12];
    assign funct7_b5   = instr_i[30];
    assign cls         = classify(instr_i[6:0]);
    assign cls_o       = cls;
    assign unused_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    // Field decode per instruction class; unknown opcodes fall to safe defaults.
    always_comb begin
        alu_ctrl_o   = ALU_ADD;
        alu_src_o    = 1'b0;
        wb_sel_o     = WSEL_ALU;
        store_size_o = SIZE_W;
        load_size_o  = SIZE_W;
        case (cls)
            CLS_R: begin
                alu_ctrl_o = {funct7_b5, funct3};
            end
            CLS_I: begin
                alu_src_o  = 1'b1;
                // Only the shift-right immediates use bit 30 (srli vs srai).
                alu_ctrl_o = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
            end
            CLS_IL: begin
                alu_src_o   = 1'b1;
                wb_sel_o    = WSEL_LOAD;
                load_size_o = (funct3 == 3'b100) ? SIZE_BU : funct3[1:0];
            end
            CLS_S: begin
                alu_src_o    = 1'b1;
                store_size_o = funct3[1:0];
            end
            CLS_B: begin
                alu_ctrl_o = {1'b0, funct3};
            end
            CLS_LUI: begin
                alu_src_o = 1'b1;
                wb_sel_o  = WSEL_LUI;
            end
            CLS_AUIPC: begin
                alu_src_o = 1'b1;
                wb_sel_o  = WSEL_AUIPC;
            end
            CLS_JAL, CLS_JALR: begin
                alu_src_o = 1'b1;
                wb_sel_o  = WSEL_PC4;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Five-state multi-cycle controller: latches the instruction in FETCH and
// sequences the strobes for register file, data memory and PC update.
module multi_cycle_controller
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_code,
    input  logic        mem_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_wr_en,
    output logic        d_wr_en,
    output logic        d_rd_en,
    output logic [3:0]  ALU_Controls,
    output logic        ALUSrcMuxSel,
    output logic [2:0]  RAM2RegWSel,
    output logic [1:0]  store_size,
    output logic [1:0]  load_size,
    output logic        branch,
    output logic        JAL,
    output logic        JALR,
    output logic        illegal_instr,
    output logic [2:0]  state_o
);

    state_e     state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0] cls_raw;
    instr_cls_e cls;

    logic ir_en_raw, pc_en_raw, reg_wr_raw, d_wr_raw, d_rd_raw;
    logic branch_raw, jal_raw, jalr_raw, illegal_raw;

    instr_decoder u_decoder (
        .instr_i      (ir_q),
        .cls_o        (cls_raw),
        .alu_ctrl_o   (ALU_Controls),
        .alu_src_o    (ALUSrcMuxSel),
        .wb_sel_o     (RAM2RegWSel),
        .store_size_o (store_size),
        .load_size_o  (load_size)
    );

    assign cls = instr_cls_e'(cls_raw);

    // State and instruction register; reset returns to FETCH holding a NOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and per-state strobe generation.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_en_raw   = 1'b0;
        pc_en_raw   = 1'b0;
        reg_wr_raw  = 1'b0;
        d_wr_raw    = 1'b0;
        d_rd_raw    = 1'b0;
        branch_raw  = 1'b0;
        jal_raw     = 1'b0;
        jalr_raw    = 1'b0;
        illegal_raw = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_en_raw = 1'b1;
                ir_d      = instr_code;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    // Skip the instruction: advance PC, no writes.
                    illegal_raw = 1'b1;
                    pc_en_raw   = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                jal_raw  = (cls == CLS_JAL);
                jalr_raw = (cls == CLS_JALR);
                case (cls)
                    CLS_B: begin
                        branch_raw = 1'b1;
                        pc_en_raw  = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CLS_IL, CLS_S: state_d = ST_MEM;
                    default:       state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // Request held for the whole wait, including the ready cycle.
                d_rd_raw = (cls == CLS_IL);
                d_wr_raw = (cls == CLS_S);
                if (mem_ready) begin
                    if (cls == CLS_IL) begin
                        state_d = ST_WB;
                    end else begin
                        pc_en_raw = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_wr_raw = 1'b1;
                pc_en_raw  = 1'b1;
                jal_raw    = (cls == CLS_JAL);
                jalr_raw   = (cls == CLS_JALR);
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are forced low for as long as reset is held.
    assign ir_en         = ir_en_raw   & reset;
    assign pc_en         = pc_en_raw   & reset;
    assign reg_wr_en     = reg_wr_raw  & reset;
    assign d_wr_en       = d_wr_raw    & reset;
    assign d_rd_en       = d_rd_raw    & reset;
    assign branch        = branch_raw  & reset;
    assign JAL           = jal_raw     & reset;
    assign JALR          = jalr_raw    & reset;
    assign illegal_instr = illegal_raw & reset;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomised bench for multi_cycle_controller: a per-instruction schedule
// model predicts every cycle's outputs, a negedge process compares them.
module tb_multi_cycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] instr_code;
    logic        mem_ready;
    logic        ir_en, pc_en, reg_wr_en, d_wr_en, d_rd_en;
    logic [3:0]  ALU_Controls;
    logic        ALUSrcMuxSel;
    logic [2:0]  RAM2RegWSel;
    logic [1:0]  store_size, load_size;
    logic        branch, JAL, JALR, illegal_instr;
    logic [2:0]  state_o;

    multi_cycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .instr_code    (instr_code),
        .mem_ready     (mem_ready),
        .ir_en         (ir_en),
        .pc_en         (pc_en),
        .reg_wr_en     (reg_wr_en),
        .d_wr_en       (d_wr_en),
        .d_rd_en       (d_rd_en),
        .ALU_Controls  (ALU_Controls),
        .ALUSrcMuxSel  (ALUSrcMuxSel),
        .RAM2RegWSel   (RAM2RegWSel),
        .store_size    (store_size),
        .load_size     (load_size),
        .branch        (branch),
        .JAL           (JAL),
        .JALR          (JALR),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    localparam int C_R = 0, C_I = 1, C_IL = 2, C_S = 3, C_B = 4;
    localparam int C_LUI = 5, C_AUIPC = 6, C_JAL = 7, C_JALR = 8, C_BAD = 9;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;

    typedef struct {
        int         k;
        logic [2:0] st;
        logic [8:0] strb;   // {ir,pc,rw,dw,dr,ill,br,jal,jalr}
        logic       dec_v;
        logic [3:0] alu;
        logic       src;
        logic [2:0] wsel;
        logic [1:0] ss;
        logic [1:0] ls;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    logic [15:0] pc_mask, rw_mask, dw_mask, dr_mask, br_mask, ill_mask;
    logic [2:0]  obs_state[16];
    logic [3:0]  obs_alu[16];
    logic [2:0]  obs_wsel[16];
    logic [1:0]  obs_ss[16];
    logic [1:0]  obs_ls[16];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, k, act, want);
        end
    endtask

    function automatic int m_cls(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return C_R;
            7'h13:   return C_I;
            7'h03:   return C_IL;
            7'h23:   return C_S;
            7'h63:   return C_B;
            7'h37:   return C_LUI;
            7'h17:   return C_AUIPC;
            7'h6F:   return C_JAL;
            7'h67:   return C_JALR;
            default: return C_BAD;
        endcase
    endfunction

    // Datapath selects implied by the instruction word.
    function automatic exp_t m_decode(input logic [31:0] w);
        exp_t e;
        logic [2:0] f3;
        f3 = w[14:12];
        e = '{k: 0, st: 3'd0, strb: 9'd0, dec_v: 1'b0, alu: 4'd0, src: 1'b0,
              wsel: 3'd0, ss: 2'b10, ls: 2'b10};
        case (m_cls(w))
            C_R:     e.alu = {w[30], f3};
            C_I:     begin e.src = 1'b1; e.alu = (f3 == 3'd5) ? {w[30], f3} : {1'b0, f3}; end
            C_IL:    begin e.src = 1'b1; e.wsel = 3'd1; e.ls = (f3 == 3'd4) ? 2'b11 : f3[1:0]; end
            C_S:     begin e.src = 1'b1; e.ss = f3[1:0]; end
            C_B:     e.alu = {1'b0, f3};
            C_LUI:   begin e.src = 1'b1; e.wsel = 3'd2; end
            C_AUIPC: begin e.src = 1'b1; e.wsel = 3'd3; end
            C_JAL, C_JALR: begin e.src = 1'b1; e.wsel = 3'd4; end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction; rst_at is the cycle index to pull reset (or -1).
    task automatic run_instr(input logic [31:0] w, input int wait_n, input int rst_at);
        int   c;
        int   ph[$];
        exp_t d, e;
        logic ir, pc, rw, dw, dr, ill, br, jl, jr;
        c = m_cls(w);
        d = m_decode(w);
        ph = '{P_F, P_D};
        if (c != C_BAD) ph.push_back(P_E);
        if (c == C_IL || c == C_S)
            for (int i = 0; i <= wait_n; i++) ph.push_back(P_M);
        if (c != C_BAD && c != C_B && c != C_S) ph.push_back(P_W);
        $display("instr word=%08h class=%0d wait=%0d rst_at=%0d cycles=%0d", w, c, wait_n, rst_at, ph.size());
        for (int j = 0; j < ph.size(); j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                pc_mask = '0; rw_mask = '0; dw_mask = '0;
                dr_mask = '0; br_mask = '0; ill_mask = '0;
            end
            instr_code = (j == 0) ? w : $urandom();
            mem_ready  = (ph[j] == P_M) ? ((j - 3) == wait_n) : 1'($urandom_range(0, 1));
            reset      = (j == rst_at) ? 1'b0 : 1'b1;
            {ir, pc, rw, dw, dr, ill, br, jl, jr} = '0;
            case (ph[j])
                P_F: ir = 1'b1;
                P_D: begin ill = (c == C_BAD); pc = (c == C_BAD); end
                P_E: begin br = (c == C_B); pc = (c == C_B); jl = (c == C_JAL); jr = (c == C_JALR); end
                P_M: begin dr = (c == C_IL); dw = (c == C_S); pc = (c == C_S) && ((j - 3) == wait_n); end
                default: begin rw = 1'b1; pc = 1'b1; jl = (c == C_JAL); jr = (c == C_JALR); end
            endcase
            e       = d;
            e.k     = j;
            e.st    = 3'(ph[j]);
            e.dec_v = (j >= 1);
            e.strb  = (j == rst_at) ? 9'd0 : {ir, pc, rw, dw, dr, ill, br, jl, jr};
            exp_q.push_back(e);
            if (j == rst_at) begin
                @(posedge clk); #1;
                reset     = 1'b0;
                mem_ready = 1'b0;
                e         = m_decode(32'h0000_0013);
                e.k       = j + 1;
                e.dec_v   = 1'b1;
                exp_q.push_back(e);
                return;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Compare process: one expectation per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", e.k, state_o, e.st);
                chk("strobes", e.k,
                    {ir_en, pc_en, reg_wr_en, d_wr_en, d_rd_en, illegal_instr, branch, JAL, JALR}, e.strb);
                if (e.dec_v)
                    chk("decode", e.k, {ALU_Controls, ALUSrcMuxSel, RAM2RegWSel, store_size, load_size},
                        {e.alu, e.src, e.wsel, e.ss, e.ls});
                if (e.k < 16) begin
                    pc_mask[e.k]  = pc_en;
                    rw_mask[e.k]  = reg_wr_en;
                    dw_mask[e.k]  = d_wr_en;
                    dr_mask[e.k]  = d_rd_en;
                    br_mask[e.k]  = branch;
                    ill_mask[e.k] = illegal_instr;
                    obs_state[e.k] = state_o;
                    obs_alu[e.k]   = ALU_Controls;
                    obs_wsel[e.k]  = RAM2RegWSel;
                    obs_ss[e.k]    = store_size;
                    obs_ls[e.k]    = load_size;
                end
            end
        end
    end

    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    initial begin
        exp_t e;
        logic [31:0] w;
        int c;
        reset = 1'b0; instr_code = '0; mem_ready = 1'b0;
        pc_mask = '0; rw_mask = '0; dw_mask = '0; dr_mask = '0; br_mask = '0; ill_mask = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = m_decode(32'h0000_0013);
            e.k = i; e.dec_v = 1'b1;
            exp_q.push_back(e);
        end
        settle();

        run_instr(32'h002081B3, 0, -1); settle();   // add x3,x1,x2
        chk("add_pc_cycles", 0, pc_mask, 16'h0008);
        chk("add_wr_cycles", 0, rw_mask, 16'h0008);
        chk("add_wsel", 3, obs_wsel[3], 3'd0);

        run_instr(32'h0000A183, 2, -1); settle();   // lw x3,0(x1)
        chk("lw_rd_cycles", 0, dr_mask, 16'h0038);
        chk("lw_wr_cycles", 0, rw_mask, 16'h0040);
        chk("lw_wsel", 6, obs_wsel[6], 3'd1);
        chk("lw_size", 6, obs_ls[6], 2'b10);

        run_instr(32'h0030A023, 0, -1); settle();   // sw x3,0(x1)
        chk("sw_wr_cycles", 0, dw_mask, 16'h0008);
        chk("sw_pc_cycles", 0, pc_mask, 16'h0008);
        chk("sw_no_regwr", 0, rw_mask, 16'h0000);
        chk("sw_size", 3, obs_ss[3], 2'b10);

        run_instr(32'h00208463, 0, -1); settle();   // beq x1,x2,8
        chk("beq_br_cycles", 0, br_mask, 16'h0004);
        chk("beq_pc_cycles", 0, pc_mask, 16'h0004);
        chk("beq_alu", 2, obs_alu[2], 4'b0000);

        run_instr(32'hFFFFFFFF, 0, -1); settle();   // unknown opcode
        chk("ill_pulse", 0, ill_mask, 16'h0002);
        chk("ill_pc", 0, pc_mask, 16'h0002);
        chk("ill_writes", 0, rw_mask | dw_mask | dr_mask, 16'h0000);

        run_instr(32'h0030A023, 5, 3); settle();    // reset during store MEM
        chk("rst_mem_state", 3, obs_state[3], 3'd3);
        chk("rst_next_state", 4, obs_state[4], 3'd0);
        chk("rst_no_write", 0, dw_mask, 16'h0000);
        chk("rst_no_pc", 0, pc_mask, 16'h0000);

        for (int n = 0; n < 300; n++) begin
            w = $urandom();
            c = $urandom_range(0, 9);
            if (c < 9) begin
                w[6:0] = ops[c];
            end else begin
                while (m_cls(w) != C_BAD) w[6:0] = 7'($urandom_range(0, 127));
            end
            run_instr(w, $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
        end
        settle();
        chk("queue_drained", 0, exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  reset is synchronous and active-low.
REQ-003 instr_code  input  32  instruction word from instruction memory; valid in FETCH.
REQ-004 mem_ready  input  1  data memory completion; sampled only in MEM.
REQ-005 ir_en  output  1  load instruction register.
REQ-006 pc_en  output  1  PC update strobe, one cycle per retired instruction.
REQ-007 reg_wr_en  output  1  register-file write strobe.
REQ-008 d_wr_en / d_rd_en  output  1 each  data-memory write / read request.
REQ-009 ALU_Controls  output  4  ALU operation code.
REQ-010 ALUSrcMuxSel  output  1  0 = rs2, 1 = immediate.
REQ-011 RAM2RegWSel  output  3  0 ALU, 1 load data, 2 LUI, 3 AUIPC, 4 PC+4.
REQ-012 store_size / load_size  output  2 each  sb/sh/sw and lb/lh/lw/lbu size codes.
REQ-013 branch, JAL, JALR  output  1 each  PC-source qualifiers.
REQ-014 illegal_instr  output  1  one-cycle pulse on unknown opcode.
REQ-015 state_o  output  3  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEM, WB.
REQ-017 FETCH SHALL assert ir_en and latch instr_code internally, then go to DECODE.
REQ-018 All decode outputs (ALU_Controls, ALUSrcMuxSel, RAM2RegWSel, sizes) SHALL derive from the latched instruction only and hold stable from DECODE until the instruction retires.
REQ-019 DECODE SHALL go to EXECUTE for R, I, IL, S, B, LUI, AUIPC, JAL and JALR opcodes.
REQ-020 Any other opcode SHALL pulse illegal_instr and pc_en in DECODE and return to FETCH with no register or memory write.
REQ-021 EXECUTE transitions: IL/S go to MEM; B goes to FETCH; all other types go to WB.
REQ-022 Branch instructions SHALL assert branch and pc_en in EXECUTE only (3-cycle instruction).
REQ-023 MEM SHALL hold d_rd_en (IL) or d_wr_en (S) continuously while mem_ready=0 and stay in MEM.
REQ-024 On mem_ready=1 in MEM, IL SHALL go to WB; S SHALL assert pc_en and go to FETCH.
REQ-025 WB SHALL assert reg_wr_en and pc_en for exactly one cycle, then go to FETCH.
REQ-026 JAL/JALR SHALL be asserted in EXECUTE and WB; RAM2RegWSel=4 in WB.
REQ-027 Latency: R/I/LUI/AUIPC/JAL/JALR 4 cycles; B 3; S 4+w; IL 5+w, where w = MEM wait cycles.
REQ-028 reg_wr_en, d_wr_en, d_rd_en, pc_en, ir_en SHALL never be asserted outside the states listed above.
REQ-029 store_size default 2'b10 and load_size default 2'b10 when not S/IL; ALU_Controls default ADD.

Reset
REQ-030 With reset=0 at a rising edge, the next state SHALL be FETCH regardless of current state, including mid-MEM.
REQ-031 During reset all strobes, illegal_instr, branch, JAL, JALR SHALL be 0; latched instruction SHALL be 32'h0000_0013 (NOP); state_o = FETCH encoding 3'd0.

Structure
REQ-032 The state enum typedef, opcode constants and ALU code constants SHALL live in a shared package rv32i_pkg.
REQ-033 Combinational opcode/funct decode SHALL be one sub-module, instr_decoder, fed by the latched instruction; the FSM and strobe gating SHALL be in multi_cycle_controller.

Verification
REQ-034 add x3,x1,x2 (0x002081B3) -> F,D,E,WB; reg_wr_en and pc_en high in cycle 4 only, RAM2RegWSel=0.
REQ-035 lw x3,0(x1) (0x0000A183), mem_ready low 2 cycles -> MEM held 3 cycles with d_rd_en=1; WB in cycle 7 with RAM2RegWSel=1, load_size=2'b10.
REQ-036 sw x3,0(x1) (0x0030A023), mem_ready=1 -> d_wr_en and pc_en high in cycle 4 only, reg_wr_en never high, store_size=2'b10.
REQ-037 beq x1,x2,8 (0x00208463) -> branch=1 and pc_en=1 in cycle 3, ALU_Controls=4'b0000, next cycle FETCH.
REQ-038 0xFFFFFFFF -> illegal_instr and pc_en pulse in cycle 2, no write strobes, FETCH in cycle 3.
REQ-039 reset=0 during MEM of sw with mem_ready=0 -> next cycle FETCH, d_wr_en=0, no pc_en.
